// File: rtl/approx_mul_rr_sched.sv
// Shares one 2-stage 8x8 multiplier (exact or 3-term approximate) among NUM_REQ round-robin requesters.
// Latency: exactly 2 cycles from accept to resp_valid; 1 result per cycle when not stalled.
// Backpressure: a held response (resp_valid & !resp_ready) freezes both stages and drops every req_ready.
module approx_mul_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_x,
  input  logic [8*NUM_REQ-1:0] req_y,
  input  logic [NUM_REQ-1:0]   req_approx,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [15:0]          resp_z,
  output logic                 resp_approx,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);

  logic           adv;
  logic           accept;
  logic           gnt_found;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] rr_ptr;
  logic [7:0]     gnt_x;
  logic [7:0]     gnt_y;
  logic           gnt_approx;

  logic           s1_valid;
  logic [IDW-1:0] s1_id;
  logic [7:0]     s1_x;
  logic [7:0]     s1_y;
  logic           s1_approx;

  // Exact product, or the approximation that keeps y*x[7:2] plus only the three
  // top partial-product bits from x[1:0]*y (a, b as a half adder, c at weight 256).
  function automatic logic [15:0] mul_f(input logic [7:0] x, input logic [7:0] y, input logic ap);
    logic        a;
    logic        b;
    logic        c;
    logic [15:0] hi;
    a  = x[0] & y[7];
    b  = x[1] & y[6];
    c  = x[1] & y[7];
    hi = 16'(x[7:2]) * 16'(y);
    if (ap)
      mul_f = (hi << 2) + (16'(a ^ b) << 7) + (16'(a & b) << 8) + (16'(c) << 8);
    else
      mul_f = 16'(x) * 16'(y);
  endfunction

  assign adv  = !resp_valid || resp_ready;
  assign busy = s1_valid || resp_valid;

  // Round-robin pick: first valid at or above rr_ptr, otherwise wrap to the lowest valid.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && req_valid[i] && (IDW'(i) >= rr_ptr)) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && req_valid[i]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(i);
      end
    end
  end

  // One-hot ready for the winner plus its operand mux; nothing is granted during reset.
  always_comb begin
    req_ready  = '0;
    gnt_x      = '0;
    gnt_y      = '0;
    gnt_approx = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == gnt_id) begin
        req_ready[i] = !rst && adv && gnt_found;
        gnt_x        = req_x[8*i +: 8];
        gnt_y        = req_y[8*i +: 8];
        gnt_approx   = req_approx[i];
      end
    end
  end

  assign accept = |req_ready;

  // Stage 1: capture the granted operands; empties when advancing without an accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      s1_x      <= '0;
      s1_y      <= '0;
      s1_approx <= 1'b0;
    end else if (adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_id     <= gnt_id;
        s1_x      <= gnt_x;
        s1_y      <= gnt_y;
        s1_approx <= gnt_approx;
      end
    end
  end

  // Stage 2: compute the product; this register is the response channel itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_z      <= '0;
      resp_approx <= 1'b0;
    end else if (adv) begin
      resp_valid  <= s1_valid;
      resp_id     <= s1_id;
      resp_z      <= mul_f(s1_x, s1_y, s1_approx);
      resp_approx <= s1_approx;
    end
  end

  // Pointer moves past the winner on accept; approximate accepts bump a saturating counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      op_count <= '0;
    end else if (accept) begin
      rr_ptr <= (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);
      if (gnt_approx && (op_count != '1))
        op_count <= op_count + CNT_W'(1);
    end
  end

endmodule
